mdio_receptor: RTL

//  PHY-side MDIO responder (management slave) facing the MDIO controller. Decodes Clause-22 frames
//  (ST,OP,PHYAD,REGAD,TA,DATA) from MDC/MDIO_OUT/MDIO_OE. Write frames emit a register-write strobe.

---
 rtl/mdio_receptor_pkg.sv | 22 ++
 rtl/mdc_edge_detect.sv | 20 ++
 rtl/mdio_receptor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdio_receptor_pkg.sv
// Shared MDIO Clause-22 frame constants and the responder state encoding.
package mdio_receptor_pkg;

    localparam logic [1:0] OP_WR      = 2'b01;
    localparam logic [1:0] OP_RD      = 2'b10;
    localparam logic [1:0] ST         = 2'b01;
    localparam logic [5:0] FRAME_BITS = 6'd32;
    localparam logic [5:0] HDR_BITS   = 6'd14;
    localparam logic [5:0] TA_END     = 6'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_HEADER,
        S_WR_TA,
        S_WR_DAT,
        S_RD_TA,
        S_RD_DAT,
        S_SKIP
    } rx_state_t;

endpackage

// File: rtl/mdc_edge_detect.sv
// Single-register MDC edge detector in the clk domain; rise and fall are mutually exclusive.
module mdc_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic MDC,
    output logic rise,
    output logic fall
);

    logic mdc_q;

    always_ff @(posedge clk) begin
        if (rst) mdc_q <= 1'b0;
        else     mdc_q <= MDC;
    end

    assign rise = MDC & ~mdc_q;
    assign fall = ~MDC & mdc_q;

endmodule

// File: rtl/mdio_receptor.sv
// PHY-side MDIO responder: decodes Clause-22 frames, strobes register writes/reads,
// and serializes read data back to the controller.
module mdio_receptor
    import mdio_receptor_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA,
    output logic        FRAME_ERR
);

    logic        rise;
    logic        fall;
    rx_state_t   state;
    logic [5:0]  bit_cnt;
    logic [14:0] rx_shift;
    logic [15:0] rd_shift;
    logic        rd_cap;
    logic [11:0] hdr;
    logic        abort;

    mdc_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .MDC  (MDC),
        .rise (rise),
        .fall (fall)
    );

    // OP(2) PHYAD(5) REGAD(5), completed by the bit arriving on rise 14
    assign hdr   = {rx_shift[10:0], MDIO_OUT};
    assign abort = !MDIO_OE &&
                   (state == S_START || state == S_HEADER || state == S_WR_TA || state == S_WR_DAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            rd_shift   <= '0;
            rd_cap     <= 1'b0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_OE <= 1'b0;
            ADDR       <= '0;
            WR_DATA    <= '0;
            WR_STB     <= 1'b0;
            RD_STB     <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            FRAME_ERR <= 1'b0;
            rd_cap    <= RD_STB;
            if (rd_cap) rd_shift <= RD_DATA;

            if (rise) begin
                rx_shift <= {rx_shift[13:0], MDIO_OUT};
                bit_cnt  <= bit_cnt + 6'd1;
            end

            if (abort) begin
                FRAME_ERR <= 1'b1;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rise && MDIO_OE && MDIO_OUT == ST[1]) begin
                            state   <= S_START;
                            bit_cnt <= 6'd1;
                        end
                    end
                    S_START: begin
                        if (rise) begin
                            if (MDIO_OUT == ST[0]) begin
                                state <= S_HEADER;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= S_IDLE;
                            end
                        end
                    end
                    S_HEADER: begin
                        if (rise && bit_cnt == HDR_BITS - 6'd1) begin
                            ADDR <= hdr[4:0];
                            if (hdr[9:5] != PHY_ADDR) begin
                                state <= S_SKIP;
                            end else if (hdr[11:10] == OP_WR) begin
                                state <= S_WR_TA;
                            end else if (hdr[11:10] == OP_RD) begin
                                state  <= S_RD_TA;
                                RD_STB <= 1'b1;
                            end else begin
                                FRAME_ERR <= 1'b1;
                                state     <= S_SKIP;
                            end
                        end
                    end
                    S_WR_TA: begin
                        if (rise && bit_cnt == TA_END - 6'd1) state <= S_WR_DAT;
                    end
                    S_WR_DAT: begin
                        if (rise && bit_cnt == FRAME_BITS - 6'd1) begin
                            WR_DATA <= {rx_shift, MDIO_OUT};
                            WR_STB  <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                    S_RD_TA: begin
                        // Drive only on falls so the controller samples stable data on its rise
                        if (fall && bit_cnt == TA_END - 6'd1) begin
                            MDIO_IN_OE <= 1'b1;
                            MDIO_IN    <= 1'b0;
                        end else if (fall && bit_cnt == TA_END) begin
                            MDIO_IN  <= rd_shift[15];
                            rd_shift <= {rd_shift[14:0], 1'b0};
                            state    <= S_RD_DAT;
                        end
                    end
                    S_RD_DAT: begin
                        if (fall) begin
                            if (bit_cnt == FRAME_BITS) begin
                                MDIO_IN_OE <= 1'b0;
                                MDIO_IN    <= 1'b0;
                                state      <= S_IDLE;
                            end else begin
                                MDIO_IN  <= rd_shift[15];
                                rd_shift <= {rd_shift[14:0], 1'b0};
                            end
                        end
                    end
                    S_SKIP: begin
                        if (rise && bit_cnt == FRAME_BITS - 6'd1) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
